// File: rtl/calc_ctrl_pkg.sv
// Shared constants for the calculator control sequencer: default sizing plus the
// stage indices the datapath decodes from stage_idx.
package calc_ctrl_pkg;

   localparam int DEF_NUM_STAGES      = 4;
   localparam int DEF_LOAD_DELAY      = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

   localparam int ENTER_A = 0;
   localparam int ENTER_B = 1;
   localparam int OPERATE = 2;
   localparam int RESULT  = 3;

   localparam int DEF_LOAD_STAGE = OPERATE;

   // What the stage FSM does this cycle; clear outranks step when both arrive together.
   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_STEP,
      ACT_CLEAR
   } seq_action_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser and run-length debouncer for one raw push-button;
// emits a one-cycle strobe when the debounced level rises.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] count;
   logic          level;

   // The level only flips after the synchronised value has disagreed with it for a
   // full run of DEBOUNCE_CYCLES; any agreeing sample restarts the run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync  <= '0;
         count <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         press <= 1'b0;
         if (sync[1] == level) begin
            count <= '0;
         end else if (count == LAST) begin
            count <= '0;
            level <= ~level;
            press <= ~level;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/calc_control_seq.sv
// Control sequencer for the calculator datapath: debounced step/clear buttons drive a
// wrapping stage register, a clear pulse for the entry register and a delayed load strobe.
module calc_control_seq
   import calc_ctrl_pkg::*;
#(
   parameter int NUM_STAGES      = DEF_NUM_STAGES,
   parameter int LOAD_STAGE      = DEF_LOAD_STAGE,
   parameter int LOAD_DELAY      = DEF_LOAD_DELAY,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          btn_step,
   input  logic                          btn_clear,
   output logic [NUM_STAGES-1:0]         control,
   output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
   output logic                          clear_input,
   output logic                          load_pulse
);

   localparam int IW = $clog2(NUM_STAGES);
   localparam logic [IW-1:0] LAST_STAGE = IW'(NUM_STAGES - 1);
   localparam logic [IW-1:0] LOAD_IDX   = IW'(LOAD_STAGE);

   logic                  step_press;
   logic                  clear_press;
   seq_action_e           action;
   logic [IW-1:0]         stage_next;
   logic [NUM_STAGES-1:0] control_next;
   logic                  entry;
   logic [LOAD_DELAY-1:0] delay_line;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_step),
      .press (step_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_btn (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_clear),
      .press (clear_press)
   );

   // Only a step can enter the load stage; a clear back to stage 0 never counts as an entry.
   always_comb begin
      action       = ACT_NONE;
      stage_next   = stage_idx;
      control_next = '0;
      entry        = 1'b0;
      if (clear_press) begin
         action = ACT_CLEAR;
      end else if (step_press) begin
         action = ACT_STEP;
      end
      case (action)
         ACT_CLEAR: stage_next = '0;
         ACT_STEP: begin
            stage_next = (stage_idx == LAST_STAGE) ? '0 : stage_idx + 1'b1;
            entry      = (stage_next == LOAD_IDX);
         end
         default: ;
      endcase
      control_next[stage_next] = 1'b1;
   end

   // A pending load keeps shifting through later steps but is dropped by a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_idx   <= '0;
         control     <= NUM_STAGES'(1);
         clear_input <= 1'b0;
         delay_line  <= '0;
         load_pulse  <= 1'b0;
      end else begin
         stage_idx   <= stage_next;
         control     <= control_next;
         clear_input <= (action != ACT_NONE);
         if (action == ACT_CLEAR) begin
            delay_line <= '0;
            load_pulse <= 1'b0;
         end else begin
            delay_line <= (delay_line << 1) | LOAD_DELAY'(entry);
            load_pulse <= delay_line[LOAD_DELAY-1];
         end
      end
   end

endmodule

// File: tb/tb_calc_control_seq.sv
// Bench for calc_control_seq: an event-level reference model checked every cycle,
// plus directed button scenarios with hand-computed expectations.
module tb_calc_control_seq;

   localparam int NS = 4;
   localparam int LS = 2;
   localparam int LD = 2;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          btn_step = 1'b0;
   logic          btn_clear = 1'b0;
   logic [NS-1:0] control;
   logic [1:0]    stage_idx;
   logic          clear_input;
   logic          load_pulse;

   int checks = 0;
   int errors = 0;

   calc_control_seq #(
      .NUM_STAGES      (NS),
      .LOAD_STAGE      (LS),
      .LOAD_DELAY      (LD),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_step    (btn_step),
      .btn_clear   (btn_clear),
      .control     (control),
      .stage_idx   (stage_idx),
      .clear_input (clear_input),
      .load_pulse  (load_pulse)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Reference model: raw samples per edge, a button level flips once the last D
   // synchronised samples all disagree with it, and accepted presses act one edge later.
   int m_cyc = 0;
   int m_stage = 0;
   bit m_lvl_step = 1'b0;
   bit m_lvl_clear = 1'b0;
   bit m_pend_step = 1'b0;
   bit m_pend_clear = 1'b0;
   bit exp_clear_input = 1'b0;
   bit exp_load = 1'b0;
   int m_loads[$];
   bit q_step[$];
   bit q_clear[$];

   function automatic bit all_differ(input bit q[$], input bit lvl);
      if (q.size() < D + 2) return 1'b0;
      for (int k = 2; k <= D + 1; k++)
         if (q[k] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_stage         = 0;
         m_lvl_step      = 1'b0;
         m_lvl_clear     = 1'b0;
         m_pend_step     = 1'b0;
         m_pend_clear    = 1'b0;
         exp_clear_input = 1'b0;
         exp_load        = 1'b0;
         m_loads.delete();
         q_step.delete();
         q_clear.delete();
         for (int k = 0; k < D + 2; k++) begin
            q_step.push_back(1'b0);
            q_clear.push_back(1'b0);
         end
      end else begin
         m_cyc++;
         exp_clear_input = m_pend_step | m_pend_clear;
         exp_load        = 1'b0;
         if (m_pend_clear) begin
            m_stage = 0;
            m_loads.delete();
         end else begin
            for (int k = m_loads.size() - 1; k >= 0; k--) begin
               if (m_loads[k] == m_cyc) begin
                  exp_load = 1'b1;
                  m_loads.delete(k);
               end
            end
            if (m_pend_step) begin
               m_stage = (m_stage + 1) % NS;
               if (m_stage == LS) m_loads.push_back(m_cyc + LD);
            end
         end
         q_step.push_front(btn_step);
         q_clear.push_front(btn_clear);
         void'(q_step.pop_back());
         void'(q_clear.pop_back());
         m_pend_step  = 1'b0;
         m_pend_clear = 1'b0;
         if (all_differ(q_step, m_lvl_step)) begin
            m_lvl_step  = ~m_lvl_step;
            m_pend_step = m_lvl_step;
         end
         if (all_differ(q_clear, m_lvl_clear)) begin
            m_lvl_clear  = ~m_lvl_clear;
            m_pend_clear = m_lvl_clear;
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("model_control", int'(control), 1 << m_stage);
      checkOutput("model_stage_idx", int'(stage_idx), m_stage);
      checkOutput("model_clear_input", int'(clear_input), int'(exp_clear_input));
      checkOutput("model_load_pulse", int'(load_pulse), int'(exp_load));
   end

   // Hold the buttons at the given levels for a number of edges; returns 1 time unit after the last edge.
   task automatic applyStimulus(input bit s, input bit c, input int cycles);
      btn_step  = s;
      btn_clear = c;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Idle after reset
      applyStimulus(1'b0, 1'b0, 20);
      checkOutput("idle_control", int'(control), 1);
      checkOutput("idle_stage", int'(stage_idx), 0);
      checkOutput("idle_clear", int'(clear_input), 0);
      checkOutput("idle_load", int'(load_pulse), 0);

      // Single held step press: advance at edge 7 only
      applyStimulus(1'b1, 1'b0, 6);
      checkOutput("step_e6_stage", int'(stage_idx), 0);
      checkOutput("step_e6_clear", int'(clear_input), 0);
      waitEdges(1);
      checkOutput("step_e7_stage", int'(stage_idx), 1);
      checkOutput("step_e7_control", int'(control), 2);
      checkOutput("step_e7_clear", int'(clear_input), 1);
      waitEdges(1);
      checkOutput("step_e8_clear", int'(clear_input), 0);
      waitEdges(2);
      checkOutput("step_held_stage", int'(stage_idx), 1);
      applyStimulus(1'b0, 1'b0, 12);

      // Second press enters the load stage at T; load at T+2
      applyStimulus(1'b1, 1'b0, 7);
      checkOutput("load_T_stage", int'(stage_idx), 2);
      waitEdges(1);
      checkOutput("load_T1", int'(load_pulse), 0);
      waitEdges(1);
      checkOutput("load_T2", int'(load_pulse), 1);
      waitEdges(1);
      checkOutput("load_T3", int'(load_pulse), 0);
      applyStimulus(1'b0, 1'b0, 12);
      applyStimulus(1'b1, 1'b0, 8);
      applyStimulus(1'b0, 1'b0, 12);
      checkOutput("third_stage", int'(stage_idx), 3);
      applyStimulus(1'b1, 1'b0, 8);
      applyStimulus(1'b0, 1'b0, 12);
      checkOutput("wrap_control", int'(control), 1);
      checkOutput("wrap_stage", int'(stage_idx), 0);

      // Short glitch is rejected
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 15);
      checkOutput("glitch_stage", int'(stage_idx), 0);

      // Bounce then steady: one advance 7 edges after steady level starts
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 6);
      checkOutput("bounce_e6_stage", int'(stage_idx), 0);
      waitEdges(1);
      checkOutput("bounce_e7_stage", int'(stage_idx), 1);
      applyStimulus(1'b0, 1'b0, 12);

      // Step and clear together in stage 1: clear wins, one clear pulse
      applyStimulus(1'b1, 1'b1, 7);
      checkOutput("both_stage", int'(stage_idx), 0);
      checkOutput("both_clear", int'(clear_input), 1);
      waitEdges(1);
      checkOutput("both_clear_end", int'(clear_input), 0);
      applyStimulus(1'b0, 1'b0, 12);

      // Clear one edge after entering the load stage flushes the pending load
      applyStimulus(1'b1, 1'b0, 8);
      applyStimulus(1'b0, 1'b0, 12);
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b1, 6);
      checkOutput("flush_T_stage", int'(stage_idx), 2);
      waitEdges(1);
      checkOutput("flush_T1_stage", int'(stage_idx), 0);
      waitEdges(1);
      checkOutput("flush_T2_load", int'(load_pulse), 0);
      applyStimulus(1'b0, 1'b0, 12);

      // Reset with a load pending and a clear debounce mid-count
      applyStimulus(1'b1, 1'b0, 8);
      applyStimulus(1'b0, 1'b0, 12);
      applyStimulus(1'b1, 1'b0, 5);
      applyStimulus(1'b1, 1'b1, 3);
      checkOutput("pre_reset_stage", int'(stage_idx), 2);
      reset     = 1'b1;
      btn_step  = 1'b0;
      btn_clear = 1'b0;
      #1;
      checkOutput("async_reset_control", int'(control), 1);
      checkOutput("async_reset_stage", int'(stage_idx), 0);
      checkOutput("async_reset_load", int'(load_pulse), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 15);
      checkOutput("post_reset_stage", int'(stage_idx), 0);
      checkOutput("post_reset_load", int'(load_pulse), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
